// File: rtl/cu_sequencer_if.sv
// Handshake/bus bundle between cu_sequencer and the datapath it steers.
// master = sequencer side, slave = datapath/testbench side.
interface cu_sequencer_if #(
    parameter int NREGS = 16
) ();
    logic             stop;
    logic [31:0]      IR;
    logic             con;
    logic             mem_ready;
    logic [29:0]      ctrl;
    logic [NREGS-1:0] R_enableIn;
    logic [31:0]      trap_vec;
    logic             run;

    modport master (
        input  stop, IR, con, mem_ready,
        output ctrl, R_enableIn, trap_vec, run
    );

    modport slave (
        output stop, IR, con, mem_ready,
        input  ctrl, R_enableIn, trap_vec, run
    );
endinterface

// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer: one state per clock, one-hot strobes decoded from state.
// Optional illegal-opcode trap enabled by defining CU_TRAP_EN.
module cu_sequencer #(
    parameter int          NREGS       = 16,
    parameter int          LINK_REG    = 15,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    cu_sequencer_if.master    bus
);
    typedef enum logic [5:0] {
        S_RESET, S_F0, S_F1, S_F2, S_F3,
        S_A1, S_A2, S_WB, S_IM1, S_L1, S_I2, S_LS3,
        S_LD4, S_LD5, S_ST4, S_ST5,
        S_MD1, S_MD2, S_MD3, S_MD4, S_NN1,
        S_BR1, S_BR2, S_BR4, S_JR1, S_JAL1,
        S_IN1, S_OUT1, S_MFHI1, S_MFLO1, S_NOP1, S_TRAP1, S_HALT
    } state_t;

    localparam int B_PCOUT = 0,  B_PCIN = 1,  B_INCPC = 2,  B_MARIN = 3;
    localparam int B_MDRIN = 4,  B_MDROUT = 5, B_READ = 6,  B_RAMWE = 7;
    localparam int B_IRIN = 8,   B_GRA = 9,   B_GRB = 10,   B_GRC = 11;
    localparam int B_RIN = 12,   B_ROUT = 13, B_BAOUT = 14, B_COUT = 15;
    localparam int B_YIN = 16,   B_ZLIN = 17, B_ZHIN = 18,  B_ZLOUT = 19;
    localparam int B_ZHOUT = 20, B_HIIN = 21, B_LOIN = 22,  B_HIOUT = 23;
    localparam int B_LOOUT = 24, B_CONIN = 25, B_INPOUT = 26, B_OUTPEN = 28;
    localparam int B_TRAP = 29;

    localparam logic [4:0] OP_LD = 5'd0, OP_ST = 5'd2, OP_BR = 5'd19;

    state_t           state_q, state_d, fsm_next_s;
    logic [29:0]      ctrl_q, ctrl_d;
    logic [NREGS-1:0] ren_q, ren_d;
    logic             run_q, run_d;
    logic [4:0]       opcode_s;

    assign opcode_s = bus.IR[31:27];

    function automatic state_t first_exec(input logic [4:0] op);
        state_t s;
        case (op)
            5'd0, 5'd1, 5'd2:                           s = S_L1;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd10, 5'd11:                               s = S_A1;
            5'd12, 5'd13, 5'd14:                        s = S_IM1;
            5'd15, 5'd16:                               s = S_MD1;
            5'd17, 5'd18:                               s = S_NN1;
            5'd19:                                      s = S_BR1;
            5'd20:                                      s = S_JR1;
            5'd21:                                      s = S_JAL1;
            5'd22:                                      s = S_IN1;
            5'd23:                                      s = S_OUT1;
            5'd24:                                      s = S_MFHI1;
            5'd25:                                      s = S_MFLO1;
            5'd26:                                      s = S_NOP1;
            5'd27:                                      s = S_HALT;
`ifdef CU_TRAP_EN
            default:                                    s = S_TRAP1;
`else
            default:                                    s = S_NOP1;
`endif
        endcase
        return s;
    endfunction

    function automatic logic [29:0] strobes_of(input state_t s);
        logic [29:0] c;
        c = 30'd0;
        case (s)
            S_F0:    begin c[B_PCOUT] = 1'b1; c[B_MARIN] = 1'b1; end
            S_F1:    begin c[B_READ] = 1'b1; c[B_MDRIN] = 1'b1; end
            S_F2:    begin c[B_MDROUT] = 1'b1; c[B_IRIN] = 1'b1; end
            S_F3:    begin c[B_INCPC] = 1'b1; c[B_PCIN] = 1'b1; end
            S_A1, S_IM1: begin c[B_GRB] = 1'b1; c[B_ROUT] = 1'b1; c[B_YIN] = 1'b1; end
            S_A2:    begin c[B_GRC] = 1'b1; c[B_ROUT] = 1'b1; c[B_ZLIN] = 1'b1; c[B_ZHIN] = 1'b1; end
            S_WB:    begin c[B_ZLOUT] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
            S_L1:    begin c[B_GRB] = 1'b1; c[B_BAOUT] = 1'b1; c[B_YIN] = 1'b1; end
            S_I2:    begin c[B_COUT] = 1'b1; c[B_ZLIN] = 1'b1; c[B_ZHIN] = 1'b1; end
            S_LS3:   begin c[B_ZLOUT] = 1'b1; c[B_MARIN] = 1'b1; end
            S_LD4:   begin c[B_READ] = 1'b1; c[B_MDRIN] = 1'b1; end
            S_LD5:   begin c[B_MDROUT] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
            S_ST4:   begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_MDRIN] = 1'b1; end
            S_ST5:   begin c[B_MDROUT] = 1'b1; c[B_RAMWE] = 1'b1; end
            S_MD1:   begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_YIN] = 1'b1; end
            S_MD2:   begin c[B_GRB] = 1'b1; c[B_ROUT] = 1'b1; c[B_ZLIN] = 1'b1; c[B_ZHIN] = 1'b1; end
            S_MD3:   begin c[B_ZLOUT] = 1'b1; c[B_LOIN] = 1'b1; end
            S_MD4:   begin c[B_ZHOUT] = 1'b1; c[B_HIIN] = 1'b1; end
            S_NN1:   begin c[B_GRB] = 1'b1; c[B_ROUT] = 1'b1; c[B_ZLIN] = 1'b1; end
            S_BR1:   begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_CONIN] = 1'b1; end
            S_BR2:   begin c[B_PCOUT] = 1'b1; c[B_YIN] = 1'b1; end
            S_BR4:   begin c[B_ZLOUT] = 1'b1; c[B_PCIN] = 1'b1; end
            S_JR1:   begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_PCIN] = 1'b1; end
            S_JAL1:  begin c[B_PCOUT] = 1'b1; end
            S_IN1:   begin c[B_INPOUT] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
            S_OUT1:  begin c[B_GRA] = 1'b1; c[B_ROUT] = 1'b1; c[B_OUTPEN] = 1'b1; end
            S_MFHI1: begin c[B_HIOUT] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
            S_MFLO1: begin c[B_LOOUT] = 1'b1; c[B_GRA] = 1'b1; c[B_RIN] = 1'b1; end
`ifdef CU_TRAP_EN
            S_TRAP1: begin c[B_TRAP] = 1'b1; c[B_PCIN] = 1'b1; end
`endif
            default: c = 30'd0;
        endcase
        return c;
    endfunction

    // Next-state logic; stop overrides everything except rst.
    always_comb begin
        fsm_next_s = state_q;
        case (state_q)
            S_RESET: fsm_next_s = S_F0;
            S_F0:    fsm_next_s = S_F1;
            S_F1:    fsm_next_s = bus.mem_ready ? S_F2 : S_F1;
            S_F2:    fsm_next_s = S_F3;
            S_F3:    fsm_next_s = first_exec(opcode_s);
            S_A1:    fsm_next_s = S_A2;
            S_A2:    fsm_next_s = S_WB;
            S_IM1:   fsm_next_s = S_I2;
            S_L1:    fsm_next_s = S_I2;
            // Shared Cout/Z state: branch tests con here, ld/st go to address, others write back.
            S_I2: begin
                if (opcode_s == OP_BR) begin
                    fsm_next_s = bus.con ? S_BR4 : S_F0;
                end else if ((opcode_s == OP_LD) || (opcode_s == OP_ST)) begin
                    fsm_next_s = S_LS3;
                end else begin
                    fsm_next_s = S_WB;
                end
            end
            S_LS3:   fsm_next_s = (opcode_s == OP_ST) ? S_ST4 : S_LD4;
            S_LD4:   fsm_next_s = bus.mem_ready ? S_LD5 : S_LD4;
            S_ST4:   fsm_next_s = S_ST5;
            S_ST5:   fsm_next_s = bus.mem_ready ? S_F0 : S_ST5;
            S_MD1:   fsm_next_s = S_MD2;
            S_MD2:   fsm_next_s = S_MD3;
            S_MD3:   fsm_next_s = S_MD4;
            S_NN1:   fsm_next_s = S_WB;
            S_BR1:   fsm_next_s = S_BR2;
            S_BR2:   fsm_next_s = S_I2;
            S_JAL1:  fsm_next_s = S_JR1;
            S_WB, S_LD5, S_MD4, S_BR4, S_JR1, S_IN1, S_OUT1,
            S_MFHI1, S_MFLO1, S_NOP1, S_TRAP1: fsm_next_s = S_F0;
            S_HALT:  fsm_next_s = S_HALT;
            default: fsm_next_s = S_RESET;
        endcase

        if (bus.stop) begin
            state_d = S_HALT;
        end else begin
            state_d = fsm_next_s;
        end

        ctrl_d = strobes_of(state_d);
        run_d  = (state_d != S_HALT);
        ren_d  = '0;
        if (state_d == S_JAL1) begin
            ren_d[LINK_REG] = 1'b1;
        end else begin
            ren_d = '0;
        end
    end

    // State and output registers; outputs are loaded with the decode of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            ctrl_q  <= 30'd0;
            ren_q   <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            ren_q   <= ren_d;
            run_q   <= run_d;
        end
    end

    assign bus.ctrl       = ctrl_q;
    assign bus.R_enableIn = ren_q;
    assign bus.run        = run_q;
    assign bus.trap_vec   = TRAP_VECTOR;
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer; trap expectations follow CU_TRAP_EN.
module tb_cu_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cu_sequencer_if #(.NREGS(16)) bus ();

    cu_sequencer #(.NREGS(16), .LINK_REG(15), .TRAP_VECTOR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== 30'd0 || bus.R_enableIn !== 16'd0 || bus.run !== 1'b1) begin
                n_bad++;
                $display("FAIL reset: ctrl=%h ren=%h run=%b required ctrl=0 ren=0 run=1",
                         bus.ctrl, bus.R_enableIn, bus.run);
            end
        end
        n_cmp++;
        if (bus.trap_vec !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL trap_vec: got=%h required=00000000", bus.trap_vec);
        end
    endtask

    task automatic test_add();
        logic [29:0] exp_c [7] = '{30'h50, 30'h120, 30'h6, 30'h12400, 30'h62800, 30'h81200, 30'h9};
        bus.IR = 32'h1911_8000;
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.ctrl !== 30'h9) begin
            n_bad++;
            $display("FAIL add_f0: ctrl=%h required=%h", bus.ctrl, 30'h9);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i] || bus.run !== 1'b1) begin
                n_bad++;
                $display("FAIL add_step%0d: ctrl=%h run=%b required ctrl=%h run=1",
                         i, bus.ctrl, bus.run, exp_c[i]);
            end
        end
    endtask

    task automatic test_ld_wait();
        logic [29:0] exp_c [14] = '{30'h50, 30'h50, 30'h50, 30'h50, 30'h120, 30'h6, 30'h14400,
                                    30'h68000, 30'h80008, 30'h50, 30'h50, 30'h50, 30'h1220, 30'h9};
        logic        mr [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.IR = 32'h0000_0000;
        for (int i = 0; i < 14; i++) begin
            bus.mem_ready = mr[i];
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i]) begin
                n_bad++;
                $display("FAIL ld_step%0d: ctrl=%h required=%h", i, bus.ctrl, exp_c[i]);
            end
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_st_wait();
        logic [29:0] exp_c [10] = '{30'h50, 30'h120, 30'h6, 30'h14400, 30'h68000, 30'h80008,
                                    30'h2210, 30'hA0, 30'hA0, 30'h9};
        logic        mr [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.IR = 32'h1000_0000;
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = mr[i];
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i]) begin
                n_bad++;
                $display("FAIL st_step%0d: ctrl=%h required=%h", i, bus.ctrl, exp_c[i]);
            end
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_branch();
        logic [29:0] exp_nt [7] = '{30'h50, 30'h120, 30'h6, 30'h2002200, 30'h10001, 30'h68000, 30'h9};
        logic [29:0] exp_t  [8] = '{30'h50, 30'h120, 30'h6, 30'h2002200, 30'h10001, 30'h68000,
                                    30'h80002, 30'h9};
        bus.IR  = 32'h9800_0000;
        bus.con = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_nt[i]) begin
                n_bad++;
                $display("FAIL br_nt_step%0d: ctrl=%h required=%h", i, bus.ctrl, exp_nt[i]);
            end
        end
        bus.con = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_t[i]) begin
                n_bad++;
                $display("FAIL br_t_step%0d: ctrl=%h required=%h", i, bus.ctrl, exp_t[i]);
            end
        end
        bus.con = 1'b0;
    endtask

    task automatic test_jal();
        logic [29:0] exp_c [6] = '{30'h50, 30'h120, 30'h6, 30'h1, 30'h2202, 30'h9};
        logic [15:0] exp_r [6] = '{16'h0, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0};
        bus.IR = 32'hA800_0000;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i] || bus.R_enableIn !== exp_r[i]) begin
                n_bad++;
                $display("FAIL jal_step%0d: ctrl=%h ren=%h required ctrl=%h ren=%h",
                         i, bus.ctrl, bus.R_enableIn, exp_c[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_jr();
        logic [29:0] exp_c [5] = '{30'h50, 30'h120, 30'h6, 30'h2202, 30'h9};
        bus.IR = 32'hA000_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i]) begin
                n_bad++;
                $display("FAIL jr_step%0d: ctrl=%h required=%h", i, bus.ctrl, exp_c[i]);
            end
        end
    endtask

    task automatic test_illegal();
`ifdef CU_TRAP_EN
        logic [29:0] exp_c [5] = '{30'h50, 30'h120, 30'h6, 30'h2000_0002, 30'h9};
`else
        logic [29:0] exp_c [5] = '{30'h50, 30'h120, 30'h6, 30'h0, 30'h9};
`endif
        bus.IR = 32'hF800_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i] || bus.run !== 1'b1) begin
                n_bad++;
                $display("FAIL illegal_step%0d: ctrl=%h run=%b required ctrl=%h run=1",
                         i, bus.ctrl, bus.run, exp_c[i]);
            end
        end
    endtask

    task automatic test_halt_opcode();
        logic [29:0] exp_c [3] = '{30'h50, 30'h120, 30'h6};
        bus.IR = 32'hD800_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i]) begin
                n_bad++;
                $display("FAIL halt_op_step%0d: ctrl=%h required=%h", i, bus.ctrl, exp_c[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== 30'd0 || bus.run !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_op_hold%0d: ctrl=%h run=%b required ctrl=0 run=0",
                         i, bus.ctrl, bus.run);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.ctrl !== 30'h9 || bus.run !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_op_restart: ctrl=%h run=%b required ctrl=9 run=1", bus.ctrl, bus.run);
        end
    endtask

    task automatic test_stop_mul();
        logic [29:0] exp_c [6] = '{30'h50, 30'h120, 30'h6, 30'h12200, 30'h62400, 30'h480000};
        bus.IR = 32'h7800_0000;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== exp_c[i]) begin
                n_bad++;
                $display("FAIL mul_step%0d: ctrl=%h required=%h", i, bus.ctrl, exp_c[i]);
            end
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n_cmp++;
        if (bus.ctrl !== 30'd0 || bus.run !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_halt: ctrl=%h run=%b required ctrl=0 run=0", bus.ctrl, bus.run);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.ctrl !== 30'd0 || bus.run !== 1'b0) begin
                n_bad++;
                $display("FAIL stop_hold%0d: ctrl=%h run=%b required ctrl=0 run=0",
                         i, bus.ctrl, bus.run);
            end
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (bus.ctrl !== 30'd0 || bus.run !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_rst: ctrl=%h run=%b required ctrl=0 run=1", bus.ctrl, bus.run);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.ctrl !== 30'h9) begin
            n_bad++;
            $display("FAIL stop_refetch_f0: ctrl=%h required=9", bus.ctrl);
        end
        step();
        n_cmp++;
        if (bus.ctrl !== 30'h50 || bus.run !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_refetch_f1: ctrl=%h run=%b required ctrl=50 run=1", bus.ctrl, bus.run);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.stop      = 1'b0;
        bus.IR        = 32'h0000_0000;
        bus.con       = 1'b0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_add();
        test_ld_wait();
        test_st_wait();
        test_branch();
        test_jal();
        test_jr();
        test_illegal();
        test_halt_opcode();
        test_stop_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
